nonce_target_check: RTL
=======================

NONCE_TARGET_CHECK -- requirements
Module: nonce_target_check

Interface
REQ-001 SHALL have parameter NUM_OF_NONCES, default 16, giving the number of consecutive hash words to scan (range 1..256).
REQ-002 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a scan, sampled only in IDLE.
REQ-005 SHALL have port hash_addr  input  16  base address of the NUM_OF_NONCES h0 words written by the hashing stage.
REQ-006 SHALL have port target  input  32  unsigned difficulty threshold.
REQ-007 SHALL have port done  output  1  high exactly when the FSM is in IDLE.
REQ-008 SHALL have port found  output  1  at least one scanned word is strictly below target.
REQ-009 SHALL have port found_nonce  output  32  index of the first word below target, zero-extended; 0 when found=0.
REQ-010 SHALL have ports mem_clk, mem_we (1 bit each), mem_addr (16 bits), mem_write_data (32 bits) as outputs, and mem_read_data (32 bits) as input, forming the shared testbench memory interface.

Function
REQ-011 SHALL drive mem_clk = clk, mem_we = 0 and mem_write_data = 0 at all times; the block is read-only.
REQ-012 SHALL implement states IDLE, READ, REPORT.
REQ-013 IDLE: on start=1, SHALL latch hash_addr and target, clear found/found_nonce (and min outputs, see REQ-024), zero the offset counter and go to READ.
REQ-014 READ SHALL last NUM_OF_NONCES+1 cycles; in READ cycle j, mem_addr = latched hash_addr + j for j < NUM_OF_NONCES.
REQ-015 Memory latency is one cycle: data for address j SHALL be captured in READ cycle j+1.
REQ-016 Each captured word SHALL be compared as an unsigned 32-bit value: word < target sets found; found_nonce records the lowest such index only.
REQ-017 A word equal to target SHALL NOT count as found.
REQ-018 After the last capture, the FSM SHALL go to REPORT for one cycle and then to IDLE; done SHALL fall on the edge that samples start and rise NUM_OF_NONCES+2 cycles later.
REQ-019 The found and found_nonce outputs SHALL be stable from the rising edge of done until the next accepted start.
REQ-020 start SHALL be ignored in READ and REPORT.
REQ-021 Address arithmetic SHALL wrap modulo 2^16 (hash_addr = 16'hFFFF, j = 1 reads address 0).
REQ-022 target = 0 SHALL always yield found = 0.

Reset
REQ-023 While reset_n is low, regardless of state including mid-scan: state = IDLE, done = 1, found = 0, found_nonce = 0, mem_addr = 0, min_hash = 32'hFFFFFFFF, min_nonce = 0; the scan is abandoned and not resumed.

Configuration
REQ-024 When macro NONCE_MIN_TRACK_EN is defined, the block SHALL add output ports min_hash (32 bits) and min_nonce (32 bits), giving the smallest scanned word and its lowest index. These SHALL be initialised at start to 32'hFFFFFFFF and 0, and are updated only on a strictly smaller word.
REQ-025 Without NONCE_MIN_TRACK_EN, these ports and their registers SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 NUM_OF_NONCES default, the state enum type and the 16/32-bit word widths SHALL live in shared package bitcoin_pkg, which the hashing stage also imports.
REQ-027 No sub-module is required; the comparator and the minimum-tracker SHALL be inline logic in the single module.

Verification
REQ-028 Memory words at 0x0100..0x010F = 0xFFFF0000 + i, target 0x10000000 -> done low for exactly 18 cycles, then found = 0, found_nonce = 0.
REQ-029 Same memory, but words 5 and 9 set to 0x00001234, target 0x10000000 -> found = 1, found_nonce = 5; with NONCE_MIN_TRACK_EN defined, min_hash = 0x00001234 and min_nonce = 5.
REQ-030 Word 0 = 0x10000000, target 0x10000000, all other words larger -> found = 0 (equality is not a hit).
REQ-031 hash_addr = 0xFFF8 -> observed mem_addr sequence 0xFFF8..0xFFFF, then 0x0000..0x0007, with correct results across the wrap.
REQ-032 Pulse reset_n low at READ cycle 7, then apply start with new data -> outputs are at reset values during reset, and the second scan's results are independent of the aborted scan.
REQ-033 A start pulse during READ is ignored -> a single scan, with done timing unchanged.

Source files
------------

// File: rtl/bitcoin_pkg.sv
// bitcoin_pkg: widths, default scan size and FSM state type shared by the hashing
// and nonce-check stages.
package bitcoin_pkg;

  localparam int unsigned NUM_OF_NONCES_DEF = 16;
  localparam int unsigned ADDR_W            = 16;
  localparam int unsigned WORD_W            = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/nonce_target_check.sv
// nonce_target_check: reads NUM_OF_NONCES h0 words from memory and reports the first index below target.
// Defining NONCE_MIN_TRACK_EN adds min_hash/min_nonce outputs tracking the smallest word seen.
module nonce_target_check
  import bitcoin_pkg::*;
#(
  parameter int unsigned NUM_OF_NONCES = NUM_OF_NONCES_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] hash_addr,
  input  logic [WORD_W-1:0] target,
  output logic              done,
  output logic              found,
  output logic [WORD_W-1:0] found_nonce,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_write_data,
  input  logic [WORD_W-1:0] mem_read_data
`ifdef NONCE_MIN_TRACK_EN
  ,
  output logic [WORD_W-1:0] min_hash,
  output logic [WORD_W-1:0] min_nonce
`endif
);

  localparam int unsigned      CNT_W    = $clog2(NUM_OF_NONCES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OF_NONCES);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [WORD_W-1:0]   r_target;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_found;
  logic [WORD_W-1:0]   r_found_nonce;
`ifdef NONCE_MIN_TRACK_EN
  logic [WORD_W-1:0]   r_min_hash;
  logic [WORD_W-1:0]   r_min_nonce;
`endif

  logic                w_capture;
  logic                w_hit;
  logic [WORD_W-1:0]   w_idx;

  // Read data lags the address by one cycle, so READ cycle j holds word j-1.
  assign w_capture = (r_state == READ) && (r_cnt != {CNT_W{1'b0}});
  assign w_hit     = w_capture && (mem_read_data < r_target);
  assign w_idx     = WORD_W'(r_cnt - ONE_CNT);

  // Scan FSM: address generation, compare and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_cnt         <= {CNT_W{1'b0}};
      r_target      <= {WORD_W{1'b0}};
      r_mem_addr    <= {ADDR_W{1'b0}};
      r_found       <= 1'b0;
      r_found_nonce <= {WORD_W{1'b0}};
`ifdef NONCE_MIN_TRACK_EN
      r_min_hash    <= {WORD_W{1'b1}};
      r_min_nonce   <= {WORD_W{1'b0}};
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state       <= READ;
            r_cnt         <= {CNT_W{1'b0}};
            r_target      <= target;
            r_mem_addr    <= hash_addr;
            r_found       <= 1'b0;
            r_found_nonce <= {WORD_W{1'b0}};
`ifdef NONCE_MIN_TRACK_EN
            r_min_hash    <= {WORD_W{1'b1}};
            r_min_nonce   <= {WORD_W{1'b0}};
`endif
          end
        end
        READ: begin
          r_mem_addr <= r_mem_addr + ADDR_W'(1);
          if (w_hit && !r_found) begin
            r_found       <= 1'b1;
            r_found_nonce <= w_idx;
          end
`ifdef NONCE_MIN_TRACK_EN
          if (w_capture && (mem_read_data < r_min_hash)) begin
            r_min_hash  <= mem_read_data;
            r_min_nonce <= w_idx;
          end
`endif
          if (r_cnt == LAST_CNT) begin
            r_state <= REPORT;
          end else begin
            r_cnt <= r_cnt + ONE_CNT;
          end
        end
        REPORT: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign done           = (r_state == IDLE);
  assign found          = r_found;
  assign found_nonce    = r_found_nonce;
  assign mem_clk        = clk;
  assign mem_we         = 1'b0;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = {WORD_W{1'b0}};
`ifdef NONCE_MIN_TRACK_EN
  assign min_hash       = r_min_hash;
  assign min_nonce      = r_min_nonce;
`endif

endmodule
